// File: rtl/friscv_sv_pkg.sv
// -----------------------------------------------------------------------------
// friscv_sv_pkg
// Shared types and constants for the instruction-memory UART loader:
//   uart_rx_state_t  - states of the byte receiver (friscv_uart_rx)
//   loader_state_t   - states of the image loader (friscv_imem_loader)
//   UART_FRAME_BITS  - data bits per UART frame (8N1)
// -----------------------------------------------------------------------------
package friscv_sv_pkg;

    localparam int UART_FRAME_BITS = 8;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } uart_rx_state_t;

    typedef enum logic [2:0] {
        L_LEN0,
        L_LEN1,
        L_LOAD,
        L_DONE,
        L_ERR
    } loader_state_t;

endpackage

// File: rtl/friscv_uart_rx.sv
// -----------------------------------------------------------------------------
// friscv_uart_rx
// 8N1 UART byte receiver, LSB first. The serial line is brought into the clk
// domain by a 2-flop synchroniser; everything else works on the synchronised
// value. Each start edge is confirmed at mid-bit, data bits and the stop bit
// are then sampled once per bit period.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous reset, active-high
//   uart_rx_in     in   serial input, idle high, asynchronous to clk
//   byte_out       out  last received byte (valid while byte_valid_out=1)
//   byte_valid_out out  1-cycle pulse: a byte with a good stop bit arrived
//   frame_err_out  out  1-cycle pulse: stop bit sampled low, byte discarded
// -----------------------------------------------------------------------------
module friscv_uart_rx
    import friscv_sv_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx_in,
    output logic [7:0] byte_out,
    output logic       byte_valid_out,
    output logic       frame_err_out
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_FRAME_BITS - 1);

    logic           r_rx_meta;
    logic           r_rx_sync;
    uart_rx_state_t r_state;
    uart_rx_state_t w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_shift;
    logic           r_valid;
    logic           r_err;

    // Synchroniser resets to the idle line level so no false start is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx_in;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            R_IDLE: begin
                if (!r_rx_sync) begin
                    w_state_next = R_START;
                end
            end
            R_START: begin
                // A line that is high again at mid start bit was a glitch.
                if (r_cnt == HALF_LAST) begin
                    w_state_next = r_rx_sync ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if ((r_cnt == FULL_LAST) && (r_bit_idx == LAST_BIT)) begin
                    w_state_next = R_STOP;
                end
            end
            R_STOP: begin
                if (r_cnt == FULL_LAST) begin
                    w_state_next = R_IDLE;
                end
            end
            default: w_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    r_cnt <= '0;
                end
                R_START: begin
                    r_bit_idx <= '0;
                    r_cnt     <= (r_cnt == HALF_LAST) ? '0 : r_cnt + 1'b1;
                end
                R_DATA: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt   <= '0;
                        r_valid <= r_rx_sync;
                        r_err   <= ~r_rx_sync;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign byte_out       = r_shift;
    assign byte_valid_out = r_valid;
    assign frame_err_out  = r_err;

endmodule

// File: rtl/friscv_imem_loader.sv
// -----------------------------------------------------------------------------
// friscv_imem_loader
// Receives a length-prefixed program image over UART and writes it word by
// word into instruction memory, holding the core in reset until the whole
// image is written. Image format: 16-bit little-endian word count, then
// count*4 bytes, each word little-endian. Count 0 finishes immediately; a
// count above MAX_WORDS or any framing error before completion is fatal
// until rst. CLK_FREQ_HZ / BAUD_RATE must be at least 4.
//
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous reset, active-high
//   uart_rx_in      in   serial input, idle high, 8N1
//   imem_addr_out   out  byte address of the word written (multiple of 4)
//   imem_wd_out     out  word written to instruction memory
//   imem_we_out     out  single-cycle write strobe
//   core_rst_n_out  out  active-low core reset, released once loaded
//   load_done_out   out  image fully written (sticky until rst)
//   frame_err_out   out  framing or length error (sticky until rst)
// -----------------------------------------------------------------------------
module friscv_imem_loader
    import friscv_sv_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx_in,
    output logic [ADDR_WIDTH-1:0] imem_addr_out,
    output logic [DATA_WIDTH-1:0] imem_wd_out,
    output logic                  imem_we_out,
    output logic                  core_rst_n_out,
    output logic                  load_done_out,
    output logic                  frame_err_out
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int MAX_WORDS    = 2 ** (ADDR_WIDTH - 2);
    // One extra bit so the index can reach MAX_WORDS without wrapping.
    localparam int WIDX_W       = ADDR_WIDTH - 1;

    logic [7:0]      w_rx_byte;
    logic            w_rx_valid;
    logic            w_rx_err;

    loader_state_t   r_state;
    loader_state_t   w_state_next;

    logic [7:0]      r_len_lo;
    logic [15:0]     r_count;
    logic [WIDX_W-1:0] r_word_idx;
    logic [1:0]      r_byte_idx;
    logic [23:0]     r_asm;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wd;
    logic            r_we;
    logic            r_core_rst_n;
    logic            r_done;
    logic            r_err;

    logic [15:0]     w_len_full;
    logic            w_len_too_big;
    logic            w_word_complete;
    logic            w_last_word;

    friscv_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk            (clk),
        .rst            (rst),
        .uart_rx_in     (uart_rx_in),
        .byte_out       (w_rx_byte),
        .byte_valid_out (w_rx_valid),
        .frame_err_out  (w_rx_err)
    );

    assign w_len_full      = {w_rx_byte, r_len_lo};
    assign w_len_too_big   = 32'(w_len_full) > 32'(MAX_WORDS);
    assign w_word_complete = (r_state == L_LOAD) && w_rx_valid && (r_byte_idx == 2'd3);
    assign w_last_word     = (32'(r_word_idx) + 32'd1) == 32'(r_count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= L_LEN0;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            L_LEN0: begin
                if (w_rx_err) begin
                    w_state_next = L_ERR;
                end else if (w_rx_valid) begin
                    w_state_next = L_LEN1;
                end
            end
            L_LEN1: begin
                if (w_rx_err) begin
                    w_state_next = L_ERR;
                end else if (w_rx_valid) begin
                    if (w_len_full == 16'd0) begin
                        w_state_next = L_DONE;
                    end else if (w_len_too_big) begin
                        w_state_next = L_ERR;
                    end else begin
                        w_state_next = L_LOAD;
                    end
                end
            end
            L_LOAD: begin
                // Leaving on the last word's 4th byte puts the state in
                // L_DONE in the same cycle the final strobe is driven.
                if (w_rx_err) begin
                    w_state_next = L_ERR;
                end else if (w_word_complete && w_last_word) begin
                    w_state_next = L_DONE;
                end
            end
            L_DONE:  w_state_next = L_DONE;
            L_ERR:   w_state_next = L_ERR;
            default: w_state_next = L_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len_lo     <= '0;
            r_count      <= '0;
            r_word_idx   <= '0;
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_addr       <= '0;
            r_wd         <= '0;
            r_we         <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                L_LEN0: begin
                    if (w_rx_valid) begin
                        r_len_lo <= w_rx_byte;
                    end
                end
                L_LEN1: begin
                    if (w_rx_valid) begin
                        r_count    <= w_len_full;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                    end
                end
                L_LOAD: begin
                    if (w_rx_valid) begin
                        r_byte_idx <= r_byte_idx + 1'b1;
                        case (r_byte_idx)
                            2'd0: r_asm[7:0]   <= w_rx_byte;
                            2'd1: r_asm[15:8]  <= w_rx_byte;
                            2'd2: r_asm[23:16] <= w_rx_byte;
                            default: begin
                                r_we       <= 1'b1;
                                r_wd       <= {w_rx_byte, r_asm};
                                r_addr     <= {r_word_idx[ADDR_WIDTH-3:0], 2'b00};
                                r_word_idx <= r_word_idx + 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                end
            endcase
            // Status flags follow the state one cycle late; both terminal
            // states are absorbing, so the flags are sticky until rst.
            r_done       <= (r_state == L_DONE);
            r_core_rst_n <= (r_state == L_DONE);
            r_err        <= (r_state == L_ERR);
        end
    end

    assign imem_addr_out  = r_addr;
    assign imem_wd_out    = r_wd;
    assign imem_we_out    = r_we;
    assign core_rst_n_out = r_core_rst_n;
    assign load_done_out  = r_done;
    assign frame_err_out  = r_err;

endmodule

// File: doc/friscv_imem_loader.md
Name: friscv_imem_loader

Overview:
UART program loader that sits directly upstream of the instruction memory write port. It receives a length-prefixed binary image over a serial line and writes it word-by-word into instruction memory. It holds the core in reset until the image is fully written. On completion it releases the core reset so execution starts from byte address 0.

Parameters:
CLK_FREQ_HZ, 50_000_000, frequency of clk in Hz
BAUD_RATE, 115_200, UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer divide, must be >= 4)
ADDR_WIDTH, 12, instruction memory byte-address width; MAX_WORDS = 2**(ADDR_WIDTH-2)
DATA_WIDTH, 32, memory word width (fixed to ARCH)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
uart_rx_in  in  1  serial input, idle high, 8N1, LSB first, asynchronous to clk
imem_addr_out  out  ADDR_WIDTH  byte address of the word being written (always a multiple of 4)
imem_wd_out  out  DATA_WIDTH  write data to instruction memory port A
imem_we_out  out  1  single-cycle write strobe
core_rst_n_out  out  1  active-low reset to the core; low while loading
load_done_out  out  1  image fully written; sticky until rst
frame_err_out  out  1  framing or length error; sticky until rst

Behaviour:
- Reset (async, rst=1): all outputs 0. This includes core_rst_n_out=0, so the core is held. All counters and FSM state are cleared. The rx synchroniser resets to 1.
- RX synchroniser: 2-flop synchroniser on uart_rx_in; all logic uses the synchronised value.
- RX engine, states R_IDLE, R_START, R_DATA, R_STOP:
  - R_IDLE: on sync rx=0, go to R_START and clear the baud counter.
  - R_START: at CLKS_PER_BIT/2, resample. If rx=0, go to R_DATA with bit index 0. If rx=1 (glitch), go to R_IDLE with no error.
  - R_DATA: sample every CLKS_PER_BIT, shifting LSB first. After bit 7, go to R_STOP.
  - R_STOP: sample after CLKS_PER_BIT. If rx=1, byte_valid pulses for 1 cycle. If rx=0, rx_frame_err pulses for 1 cycle and the byte is discarded. Either way, return to R_IDLE.
- Loader FSM, states L_LEN0, L_LEN1, L_LOAD, L_DONE, L_ERR:
  - L_LEN0: byte_valid latches the low byte of word_count.
  - L_LEN1: byte_valid latches the high byte (16-bit little-endian). If count == 0, go to L_DONE. If count > MAX_WORDS, go to L_ERR. Otherwise go to L_LOAD with word_idx=0 and byte_idx=0.
  - L_LOAD: bytes are assembled little-endian (byte_idx 0 goes to bits 7:0). On the 4th byte, the next cycle drives imem_we_out=1, imem_wd_out=assembled word and imem_addr_out=word_idx*4. Then word_idx increments and byte_idx wraps to 0. On the write of word count-1, go to L_DONE in the same cycle the strobe is issued.
  - L_DONE: load_done_out=1 and core_rst_n_out=1, both registered and asserted the cycle after entry. All further RX traffic is ignored: no writes, no errors.
  - L_ERR: frame_err_out=1 and core_rst_n_out stays 0. The state is absorbing until rst.
- rx_frame_err in L_LEN0, L_LEN1 or L_LOAD goes to L_ERR. A partially assembled word is never written.
- imem_addr_out and imem_wd_out hold their last written values between strobes. imem_we_out is never high for 2 consecutive cycles.
- Write latency: one clk from byte_valid of the word's 4th byte to imem_we_out.
- If rst is asserted mid-load, everything aborts immediately. Memory contents already written are left as they are. After rst is released, the loader expects a fresh length header.
- word_idx width is ADDR_WIDTH-1 bits, so MAX_WORDS is representable without wrap.

Decomposition:
- friscv_sv_pkg gains:
  - uart_rx_state_t (R_IDLE..R_STOP)
  - loader_state_t (L_LEN0..L_ERR)
  - constant UART_FRAME_BITS=8
- One sub-module, friscv_uart_rx, containing the synchroniser, baud counter and RX FSM. Its outputs are byte_out[7:0], byte_valid_out and frame_err_out. The top module contains the loader FSM and the output registers.

Test Plan (CLK_FREQ_HZ=1_000_000, BAUD_RATE=100_000, so CLKS_PER_BIT=10; ADDR_WIDTH=6, so MAX_WORDS=16):
- Send 02 00 13 00 00 00 EF BE AD DE:
  - Expect exactly 2 strobes: (addr 0x00, wd 0x00000013) and (addr 0x04, wd 0xDEADBEEF), each 1 cycle.
  - Expect load_done_out=1 and core_rst_n_out=1 one cycle after the 2nd strobe.
- Send 00 00: expect no strobes; load_done_out=1 and core_rst_n_out=1 after header byte 2.
- Send 11 00 (count 17 > 16): expect frame_err_out=1, core_rst_n_out=0, and no strobes for 20 subsequent bytes.
- Send 01 00 AA then a byte with stop bit 0: expect frame_err_out=1 and no strobe. Then assert rst: all outputs return to 0. Then send 01 00 01 02 03 04: expect strobe addr 0x00, wd 0x04030201.
- Drive a 3-clk low glitch on uart_rx_in while idle, then send 01 00 78 56 34 12: expect no error and a single strobe with wd 0x12345678.
- After L_DONE, send 5 more bytes: expect imem_we_out to stay 0, and load_done_out and core_rst_n_out to stay 1.
